sha_msg_packer: RTL and testbench

- Upstream feeder for the Dilithium SHA-3/SHAKE padder.
- Takes a byte-length-tagged message as a stream of 32-bit words from the DMA/AXI side and packs it into 64-bit padder input words.
- Generates the padder-side controls `in_ready`, `is_last` and `byte_num`, and respects the padder's `buffer_full` backpressure.
- Emits the mandatory zero-byte terminating word when the message length is a multiple of 8.

---
 rtl/sha_msg_packer_if.sv | 34 +++
 rtl/sha_msg_packer.sv | 133 +++++++++++++
 tb/tb_sha_msg_packer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha_msg_packer_if.sv
// Stream bundle between the upstream 32-bit word source and the padder.
// The packer uses the master view, the traffic source/sink the slave view.
interface sha_msg_packer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] in;
  logic        in_ready;
  logic        is_last;
  logic [2:0]  byte_num;
  logic        buffer_full;

  modport master (
    input  s_data,
    input  s_valid,
    input  buffer_full,
    output s_ready,
    output in,
    output in_ready,
    output is_last,
    output byte_num
  );

  modport slave (
    output s_data,
    output s_valid,
    output buffer_full,
    input  s_ready,
    input  in,
    input  in_ready,
    input  is_last,
    input  byte_num
  );
endinterface

// File: rtl/sha_msg_packer.sv
// Packs a length-tagged 32-bit word stream into 64-bit padder words,
// adding the zero-byte terminator when the length is a multiple of 8.
module sha_msg_packer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [1:0]       mode_in,
  output logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  sha_msg_packer_if.master bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH_HI = 3'd1;
  localparam logic [2:0] FETCH_LO = 3'd2;
  localparam logic [2:0] PRESENT  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [LEN_W-1:0] B0 = '0;
  localparam logic [LEN_W-1:0] B4 = LEN_W'(4);
  localparam logic [LEN_W-1:0] B8 = LEN_W'(8);

  logic [2:0]       state;
  logic [LEN_W-1:0] rem;
  logic [63:0]      word64;
  logic [1:0]       mode_r;
  logic             final_r;
  logic             xfer;
  logic             consume;

  // Keep the first n bytes of a big-endian word, zero the rest.
  function automatic logic [31:0] keep_bytes(
    input logic [31:0] w,
    input logic [2:0]  n
  );
    logic [31:0] r;
    case (n)
      3'd1:    r = {w[31:24], 24'h0};
      3'd2:    r = {w[31:16], 16'h0};
      3'd3:    r = {w[31:8], 8'h0};
      default: r = w;
    endcase
    return r;
  endfunction

  assign bus.s_ready = (state == FETCH_HI) | (state == FETCH_LO);
  assign bus.in_ready = (state == PRESENT);
  assign bus.in = word64;
  assign bus.is_last = bus.in_ready & final_r & ~bus.buffer_full;
  assign bus.byte_num = (bus.in_ready & final_r) ? rem[2:0] : 3'd0;

  assign xfer = bus.s_ready & bus.s_valid;
  assign consume = bus.in_ready & ~bus.buffer_full;

  assign mode = mode_r;
  assign busy = (state == FETCH_HI) | (state == FETCH_LO) |
                (state == PRESENT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rem     <= '0;
      word64  <= '0;
      mode_r  <= '0;
      final_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_r <= mode_in;
            rem    <= msg_len;
            if (msg_len == B0) begin
              word64  <= '0;
              final_r <= 1'b1;
              state   <= PRESENT;
            end else begin
              final_r <= 1'b0;
              state   <= FETCH_HI;
            end
          end
        end
        FETCH_HI: begin
          if (xfer) begin
            if (rem <= B4) begin
              word64  <= {keep_bytes(bus.s_data, rem[2:0]), 32'h0};
              final_r <= 1'b1;
              state   <= PRESENT;
            end else begin
              word64  <= {bus.s_data, 32'h0};
              final_r <= 1'b0;
              state   <= FETCH_LO;
            end
          end
        end
        FETCH_LO: begin
          if (xfer) begin
            if (rem < B8) begin
              word64[31:0] <= keep_bytes(bus.s_data,
                                         rem[2:0] - 3'd4);
              final_r <= 1'b1;
            end else begin
              word64[31:0] <= bus.s_data;
              final_r <= 1'b0;
            end
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (consume) begin
            if (final_r) begin
              state <= DONE;
            end else if (rem == B8) begin
              // Exact multiple of 8: one empty terminating word.
              rem     <= '0;
              word64  <= '0;
              final_r <= 1'b1;
            end else begin
              rem   <= rem - B8;
              state <= FETCH_HI;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_packer.sv
// Randomized bench for sha_msg_packer against a byte-level model
// of the expected padder word sequence.
module tb_sha_msg_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] msg_len = '0;
  logic [1:0]  mode_in = '0;
  logic [1:0]  mode;
  logic        busy;
  logic        done;

  sha_msg_packer_if bus();

  sha_msg_packer #(.LEN_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .msg_len(msg_len),
    .mode_in(mode_in),
    .mode(mode),
    .busy(busy),
    .done(done),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  msg [0:255];
  logic [63:0] exp_w [0:40];
  int          exp_n;
  int          exp_bn;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
  endtask

  // Padder words: 8-byte chunks of the message, zero past the end,
  // plus a final partial (possibly empty) chunk; byte_num = len % 8.
  task automatic build(input int len);
    logic [63:0] w;
    exp_n = len / 8 + 1;
    exp_bn = len % 8;
    for (int k = 0; k < exp_n; k++) begin
      w = '0;
      for (int b = 0; b < 8; b++)
        w = {w[55:0], (8*k + b < len) ? msg[8*k + b] : 8'h00};
      exp_w[k] = w;
    end
  endtask

  function automatic logic [31:0] up_word(input int i);
    return {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
  endfunction

  task automatic run_msg(input int len, input logic [1:0] md,
                         input int bf_mode, input bit vstall,
                         input bit poke, input int abort_xfers);
    int nup;
    int widx;
    int oidx;
    int cyc;
    int hold;
    bit prev_stall;
    logic [63:0] prev_in;
    nup = (len + 3) / 4;
    widx = 0;
    oidx = 0;
    cyc = 0;
    hold = 0;
    prev_stall = 0;
    prev_in = '0;
    build(len);
    @(negedge clk);
    start = 1'b1;
    msg_len = 16'(len);
    mode_in = md;
    bus.s_valid = 1'b0;
    bus.buffer_full = 1'b0;
    @(negedge clk);
    start = 1'b0;
    msg_len = 16'($urandom);
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("mode_latched", mode, md);
    while (cyc < 2000) begin
      if (abort_xfers > 0 && widx == abort_xfers) begin
        bus.s_valid = 1'b0;
        return;
      end
      if (done) break;
      start = poke && busy && ($urandom_range(0, 3) == 0);
      if (start) msg_len = 16'($urandom);
      mode_in = 2'($urandom);
      bus.s_valid = (widx < nup) && (!vstall || $urandom_range(0, 1) == 1);
      bus.s_data = (widx < nup) ? up_word(widx) : $urandom;
      case (bf_mode)
        1: bus.buffer_full = ($urandom_range(0, 2) == 0);
        2: begin
          bus.buffer_full = bus.in_ready && oidx == 1 && hold < 10;
          if (bus.buffer_full) hold++;
        end
        default: bus.buffer_full = 1'b0;
      endcase
      #1;
      if (mode !== md) chk("mode_stable", mode, md);
      if (bus.in_ready) begin
        if (prev_stall) chk("in_stable", bus.in, prev_in);
        chk("s_ready_present", bus.s_ready, 0);
        if (bus.buffer_full) begin
          chk("is_last_gated", bus.is_last, 0);
          prev_stall = 1;
          prev_in = bus.in;
        end else begin
          if (oidx < exp_n) begin
            chk("in_word", bus.in, exp_w[oidx]);
            chk("is_last", bus.is_last, (oidx == exp_n - 1));
            if (oidx == exp_n - 1)
              chk("byte_num", bus.byte_num, exp_bn);
          end else begin
            chk("extra_word", 1, 0);
          end
          oidx++;
          prev_stall = 0;
        end
      end else begin
        prev_stall = 0;
      end
      if (bus.s_ready && bus.s_valid) begin
        if (widx >= nup) chk("extra_xfer", 1, 0);
        widx++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.buffer_full = 1'b0;
    if (cyc >= 2000) chk("timeout", 1, 0);
    chk("done_set", done, 1);
    chk("busy_clear", busy, 0);
    chk("in_ready_idle", bus.in_ready, 0);
    chk("word_count", oidx, exp_n);
    chk("xfer_count", widx, nup);
    chk("mode_end", mode, md);
  endtask

  task automatic chk_reset_outs();
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_in", bus.in, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_is_last", bus.is_last, 0);
    chk("rst_byte_num", bus.byte_num, 0);
    chk("rst_mode", mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.buffer_full = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs();
    @(negedge clk);
    reset = 1'b0;

    fill_rand();
    run_msg(0, 2'd2, 0, 0, 0, 0);

    fill_rand();
    {msg[0], msg[1], msg[2], msg[3]} = 32'h01020304;
    {msg[4], msg[5], msg[6], msg[7]} = 32'h05AABBCC;
    run_msg(5, 2'd1, 0, 0, 0, 0);
    chk("t2_word", exp_w[0], 64'h0102030405000000);

    fill_rand();
    {msg[0], msg[1], msg[2], msg[3]} = 32'h00112233;
    {msg[4], msg[5], msg[6], msg[7]} = 32'h44556677;
    {msg[8], msg[9], msg[10], msg[11]} = 32'h8899AABB;
    {msg[12], msg[13], msg[14], msg[15]} = 32'hCCDDEEFF;
    run_msg(16, 2'd0, 0, 0, 0, 0);

    fill_rand();
    run_msg(12, 2'd3, 2, 0, 0, 0);

    fill_rand();
    run_msg(20, 2'd3, 0, 1, 0, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_no_word", bus.in_ready, 0);
    fill_rand();
    run_msg(3, 2'd1, 0, 0, 0, 0);

    fill_rand();
    run_msg(9, 2'd2, 1, 1, 1, 0);

    for (int t = 0; t < 25; t++) begin
      fill_rand();
      run_msg($urandom_range(0, 64), 2'($urandom), $urandom_range(0, 1),
              1'($urandom), 1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
